// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing one 64-bit RAM read port between icache and dcache refills.
// A grant stays locked for up to MAX_BEATS beats so a cache line is never interleaved.
module mem_rd_arbiter #(
  parameter int MAX_BEATS = 2,
  parameter int CNT_W     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ic_raddr_i,
  input  logic        ic_raddr_valid_i,
  input  logic [7:0]  ic_rmask_i,
  output logic        ic_rdata_ready_o,
  output logic [63:0] ic_rdata_o,
  input  logic [31:0] dc_raddr_i,
  input  logic        dc_raddr_valid_i,
  input  logic [7:0]  dc_rmask_i,
  output logic        dc_rdata_ready_o,
  output logic [63:0] dc_rdata_o,
  output logic [31:0] mem_raddr_o,
  output logic        mem_raddr_valid_o,
  output logic [7:0]  mem_rmask_o,
  input  logic        mem_rdata_ready_i,
  input  logic [63:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

  state_t           state, state_nxt;
  logic             last_gnt, last_gnt_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic             gnt_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  assign gnt_req = (state == GNT_I) ? ic_raddr_valid_i : dc_raddr_valid_i;

  // A dropped request ends the burst at once; its coincident beat is discarded.
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        beat_cnt_nxt = '0;
        if (ic_raddr_valid_i && (!dc_raddr_valid_i || last_gnt)) begin
          state_nxt    = GNT_I;
          last_gnt_nxt = 1'b0;
        end else if (dc_raddr_valid_i) begin
          state_nxt    = GNT_D;
          last_gnt_nxt = 1'b1;
        end
      end
      GNT_I, GNT_D: begin
        if (!gnt_req) begin
          state_nxt    = IDLE;
          beat_cnt_nxt = '0;
        end else if (mem_rdata_ready_i) begin
          if (beat_cnt == LAST_BEAT) begin
            state_nxt    = IDLE;
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        beat_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    mem_raddr_o       = '0;
    mem_raddr_valid_o = 1'b0;
    mem_rmask_o       = '0;
    ic_rdata_ready_o  = 1'b0;
    ic_rdata_o        = '0;
    dc_rdata_ready_o  = 1'b0;
    dc_rdata_o        = '0;
    case (state)
      GNT_I: begin
        mem_raddr_o       = ic_raddr_i;
        mem_raddr_valid_o = ic_raddr_valid_i;
        mem_rmask_o       = ic_rmask_i;
        ic_rdata_ready_o  = mem_rdata_ready_i && ic_raddr_valid_i;
        ic_rdata_o        = ic_rdata_ready_o ? mem_rdata_i : '0;
      end
      GNT_D: begin
        mem_raddr_o       = dc_raddr_i;
        mem_raddr_valid_o = dc_raddr_valid_i;
        mem_rmask_o       = dc_rmask_i;
        dc_rdata_ready_o  = mem_rdata_ready_i && dc_raddr_valid_i;
        dc_rdata_o        = dc_rdata_ready_o ? mem_rdata_i : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed self-checking bench for mem_rd_arbiter; each task drives one scenario.
// Inputs change 1 time unit after the rising edge, outputs are sampled 3 units later.
module tb_mem_rd_arbiter;

  localparam logic [31:0] IC_BASE = 32'h8000_0010;
  localparam logic [31:0] DC_BASE = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ic_raddr;
  logic        ic_raddr_valid;
  logic [7:0]  ic_rmask;
  logic        ic_rdata_ready;
  logic [63:0] ic_rdata;
  logic [31:0] dc_raddr;
  logic        dc_raddr_valid;
  logic [7:0]  dc_rmask;
  logic        dc_rdata_ready;
  logic [63:0] dc_rdata;
  logic [31:0] mem_raddr;
  logic        mem_raddr_valid;
  logic [7:0]  mem_rmask;
  logic        mem_rdata_ready;
  logic [63:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  mem_rd_arbiter #(.MAX_BEATS(2), .CNT_W(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .ic_raddr_i       (ic_raddr),
    .ic_raddr_valid_i (ic_raddr_valid),
    .ic_rmask_i       (ic_rmask),
    .ic_rdata_ready_o (ic_rdata_ready),
    .ic_rdata_o       (ic_rdata),
    .dc_raddr_i       (dc_raddr),
    .dc_raddr_valid_i (dc_raddr_valid),
    .dc_rmask_i       (dc_rmask),
    .dc_rdata_ready_o (dc_rdata_ready),
    .dc_rdata_o       (dc_rdata),
    .mem_raddr_o      (mem_raddr),
    .mem_raddr_valid_o(mem_raddr_valid),
    .mem_rmask_o      (mem_rmask),
    .mem_rdata_ready_i(mem_rdata_ready),
    .mem_rdata_i      (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Dropping both requests forces any active grant back to IDLE within one edge.
  task automatic idle_all();
    ic_raddr_valid  = 1'b0;
    dc_raddr_valid  = 1'b0;
    mem_rdata_ready = 1'b0;
    mem_rdata       = '0;
    ic_raddr        = IC_BASE;
    dc_raddr        = DC_BASE;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ic_raddr = IC_BASE; ic_rmask = 8'hFF; ic_raddr_valid = 1'b1;
    dc_raddr = DC_BASE; dc_rmask = 8'h0F; dc_raddr_valid = 1'b1;
    mem_rdata_ready = 1'b1; mem_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
    #3;
    checks++; if (mem_raddr_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_mem_valid got=%0h exp=0", mem_raddr_valid); end
    checks++; if (ic_rdata_ready !== 1'b0 || dc_rdata_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_ready got=%0b%0b exp=00", ic_rdata_ready, dc_rdata_ready); end
    tick();
    rst = 1'b1; ic_raddr_valid = 1'b0; mem_rdata_ready = 1'b0;
    tick();
    mem_rdata_ready = 1'b1; mem_rdata = 64'h3333_3333_3333_3333;
    #3;
    checks++; if (dc_rdata_ready !== 1'b1 || mem_raddr !== DC_BASE) begin failures++; $display("[TB] FAIL rst_dc_beat1 got ready=%0b addr=%0h exp ready=1 addr=%0h", dc_rdata_ready, mem_raddr, DC_BASE); end
    tick();
    mem_rdata_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (mem_raddr_valid !== 1'b0 || mem_raddr !== 32'h0 || mem_rmask !== 8'h0) begin failures++; $display("[TB] FAIL rst_mid_burst_mem got v=%0b a=%0h m=%0h exp all 0", mem_raddr_valid, mem_raddr, mem_rmask); end
    checks++; if (dc_rdata_ready !== 1'b0 || dc_rdata !== 64'h0 || ic_rdata_ready !== 1'b0 || ic_rdata !== 64'h0) begin failures++; $display("[TB] FAIL rst_mid_burst_rdata got dcr=%0b dcd=%0h icr=%0b exp 0", dc_rdata_ready, dc_rdata, ic_rdata_ready); end
    mem_rdata_ready = 1'b0;
    ic_raddr_valid = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    #3;
    checks++; if (mem_raddr_valid !== 1'b1 || mem_raddr !== IC_BASE) begin failures++; $display("[TB] FAIL rst_ic_first got v=%0b a=%0h exp v=1 a=%0h", mem_raddr_valid, mem_raddr, IC_BASE); end
    idle_all();
  endtask

  task automatic test_single_icache();
    ic_raddr = IC_BASE; ic_rmask = 8'hFF; ic_raddr_valid = 1'b1;
    #3;
    checks++; if (mem_raddr_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_c0_idle got=%0b exp=0", mem_raddr_valid); end
    tick(); #3;
    checks++; if (mem_raddr_valid !== 1'b1 || mem_raddr !== IC_BASE || mem_rmask !== 8'hFF) begin failures++; $display("[TB] FAIL single_grant got v=%0b a=%0h m=%0h exp v=1 a=%0h m=ff", mem_raddr_valid, mem_raddr, mem_rmask, IC_BASE); end
    tick();
    tick();
    mem_rdata_ready = 1'b1; mem_rdata = 64'h1111_1111_1111_1111;
    #3;
    checks++; if (ic_rdata_ready !== 1'b1 || ic_rdata !== 64'h1111_1111_1111_1111) begin failures++; $display("[TB] FAIL single_beat1 got r=%0b d=%0h exp r=1 d=1111111111111111", ic_rdata_ready, ic_rdata); end
    checks++; if (dc_rdata_ready !== 1'b0 || dc_rdata !== 64'h0) begin failures++; $display("[TB] FAIL single_dc_quiet got r=%0b d=%0h exp 0", dc_rdata_ready, dc_rdata); end
    tick();
    mem_rdata_ready = 1'b0; ic_raddr = IC_BASE + 32'd8;
    #3;
    checks++; if (mem_raddr !== 32'h8000_0018 || ic_rdata_ready !== 1'b0) begin failures++; $display("[TB] FAIL single_addr2 got a=%0h r=%0b exp a=80000018 r=0", mem_raddr, ic_rdata_ready); end
    tick();
    tick();
    mem_rdata_ready = 1'b1; mem_rdata = 64'h2222_2222_2222_2222;
    #3;
    checks++; if (ic_rdata_ready !== 1'b1 || ic_rdata !== 64'h2222_2222_2222_2222) begin failures++; $display("[TB] FAIL single_beat2 got r=%0b d=%0h exp r=1 d=2222222222222222", ic_rdata_ready, ic_rdata); end
    tick();
    mem_rdata_ready = 1'b0;
    #3;
    checks++; if (mem_raddr_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_back_idle got=%0b exp=0", mem_raddr_valid); end
    ic_raddr_valid = 1'b0;
    idle_all();
  endtask

  task automatic test_tie();
    rst = 1'b0; #2; rst = 1'b1;
    ic_raddr = IC_BASE; ic_rmask = 8'hFF; ic_raddr_valid = 1'b1;
    dc_raddr = DC_BASE; dc_rmask = 8'h0F; dc_raddr_valid = 1'b1;
    tick(); #3;
    checks++; if (mem_raddr !== IC_BASE || dc_rdata_ready !== 1'b0) begin failures++; $display("[TB] FAIL tie_first_ic got a=%0h dcr=%0b exp a=%0h dcr=0", mem_raddr, dc_rdata_ready, IC_BASE); end
    tick();
    mem_rdata_ready = 1'b1; mem_rdata = 64'h5555_0000_0000_0001;
    #3;
    checks++; if (ic_rdata_ready !== 1'b1 || dc_rdata_ready !== 1'b0) begin failures++; $display("[TB] FAIL tie_ic_beat1 got icr=%0b dcr=%0b exp 1 0", ic_rdata_ready, dc_rdata_ready); end
    tick(); #3;
    checks++; if (ic_rdata_ready !== 1'b1 || dc_rdata_ready !== 1'b0) begin failures++; $display("[TB] FAIL tie_ic_beat2 got icr=%0b dcr=%0b exp 1 0", ic_rdata_ready, dc_rdata_ready); end
    tick(); #3;
    checks++; if (mem_raddr_valid !== 1'b0 || ic_rdata_ready !== 1'b0 || dc_rdata_ready !== 1'b0) begin failures++; $display("[TB] FAIL tie_idle_gap got v=%0b icr=%0b dcr=%0b exp 0 0 0", mem_raddr_valid, ic_rdata_ready, dc_rdata_ready); end
    tick(); #3;
    checks++; if (mem_raddr !== DC_BASE || mem_rmask !== 8'h0F || dc_rdata_ready !== 1'b1 || ic_rdata_ready !== 1'b0) begin failures++; $display("[TB] FAIL tie_dc_beat1 got a=%0h m=%0h dcr=%0b icr=%0b exp a=%0h m=0f 1 0", mem_raddr, mem_rmask, dc_rdata_ready, ic_rdata_ready, DC_BASE); end
    tick(); #3;
    checks++; if (dc_rdata_ready !== 1'b1 || dc_rdata !== 64'h5555_0000_0000_0001) begin failures++; $display("[TB] FAIL tie_dc_beat2 got r=%0b d=%0h exp r=1 d=5555000000000001", dc_rdata_ready, dc_rdata); end
    tick(); #3;
    checks++; if (mem_raddr_valid !== 1'b0) begin failures++; $display("[TB] FAIL tie_end_idle got=%0b exp=0", mem_raddr_valid); end
    idle_all();
  endtask

  task automatic test_lock();
    ic_raddr = IC_BASE; ic_raddr_valid = 1'b1;
    tick(); #3;
    checks++; if (mem_raddr !== IC_BASE) begin failures++; $display("[TB] FAIL lock_grant_ic got=%0h exp=%0h", mem_raddr, IC_BASE); end
    tick();
    mem_rdata_ready = 1'b1; dc_raddr_valid = 1'b1;
    #3;
    checks++; if (ic_rdata_ready !== 1'b1 || mem_raddr !== IC_BASE || dc_rdata_ready !== 1'b0) begin failures++; $display("[TB] FAIL lock_beat1 got icr=%0b a=%0h dcr=%0b exp 1 %0h 0", ic_rdata_ready, mem_raddr, dc_rdata_ready, IC_BASE); end
    tick();
    mem_rdata_ready = 1'b0;
    #3;
    checks++; if (mem_raddr !== IC_BASE || mem_raddr_valid !== 1'b1) begin failures++; $display("[TB] FAIL lock_hold got a=%0h v=%0b exp a=%0h v=1", mem_raddr, mem_raddr_valid, IC_BASE); end
    tick();
    mem_rdata_ready = 1'b1;
    #3;
    checks++; if (ic_rdata_ready !== 1'b1 || mem_raddr !== IC_BASE) begin failures++; $display("[TB] FAIL lock_beat2 got icr=%0b a=%0h exp 1 %0h", ic_rdata_ready, mem_raddr, IC_BASE); end
    tick();
    mem_rdata_ready = 1'b0; ic_raddr_valid = 1'b0;
    #3;
    checks++; if (mem_raddr_valid !== 1'b0) begin failures++; $display("[TB] FAIL lock_idle got=%0b exp=0", mem_raddr_valid); end
    tick(); #3;
    checks++; if (mem_raddr !== DC_BASE || mem_raddr_valid !== 1'b1) begin failures++; $display("[TB] FAIL lock_dc_after got a=%0h v=%0b exp a=%0h v=1", mem_raddr, mem_raddr_valid, DC_BASE); end
    idle_all();
  endtask

  task automatic test_early_release();
    ic_raddr = IC_BASE; ic_raddr_valid = 1'b1;
    tick();
    tick();
    mem_rdata_ready = 1'b1; mem_rdata = 64'h7777_7777_7777_7777;
    #3;
    checks++; if (ic_rdata_ready !== 1'b1) begin failures++; $display("[TB] FAIL early_beat1 got=%0b exp=1", ic_rdata_ready); end
    tick();
    ic_raddr_valid = 1'b0;
    #3;
    checks++; if (ic_rdata_ready !== 1'b0 || ic_rdata !== 64'h0 || mem_raddr_valid !== 1'b0) begin failures++; $display("[TB] FAIL early_drop got r=%0b d=%0h v=%0b exp 0 0 0", ic_rdata_ready, ic_rdata, mem_raddr_valid); end
    tick();
    ic_raddr_valid = 1'b1; mem_rdata_ready = 1'b0;
    #3;
    checks++; if (mem_raddr_valid !== 1'b0) begin failures++; $display("[TB] FAIL early_idle got=%0b exp=0", mem_raddr_valid); end
    tick();
    mem_rdata_ready = 1'b1;
    #3;
    checks++; if (ic_rdata_ready !== 1'b1 || mem_raddr_valid !== 1'b1) begin failures++; $display("[TB] FAIL early_regrant_b1 got r=%0b v=%0b exp 1 1", ic_rdata_ready, mem_raddr_valid); end
    tick(); #3;
    checks++; if (ic_rdata_ready !== 1'b1) begin failures++; $display("[TB] FAIL early_regrant_b2 got=%0b exp=1", ic_rdata_ready); end
    tick();
    mem_rdata_ready = 1'b0;
    #3;
    checks++; if (mem_raddr_valid !== 1'b0) begin failures++; $display("[TB] FAIL early_cnt_cleared got=%0b exp=0", mem_raddr_valid); end
    idle_all();
  endtask

  // Three cycles per burst with ready held high: two beats, then one IDLE cycle.
  task automatic test_fairness();
    int ic_pulses = 0;
    int dc_pulses = 0;
    logic exp_i, exp_d;
    rst = 1'b0; #2; rst = 1'b1;
    ic_raddr = IC_BASE; ic_raddr_valid = 1'b1;
    dc_raddr = DC_BASE; dc_raddr_valid = 1'b1;
    mem_rdata_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      mem_rdata = 64'(k);
      #3;
      exp_i = (k % 3 != 2) && ((k / 3) % 2 == 0);
      exp_d = (k % 3 != 2) && ((k / 3) % 2 == 1);
      checks++; if (ic_rdata_ready !== exp_i || dc_rdata_ready !== exp_d) begin failures++; $display("[TB] FAIL fair_k%0d got icr=%0b dcr=%0b exp icr=%0b dcr=%0b", k, ic_rdata_ready, dc_rdata_ready, exp_i, exp_d); end
      if (exp_i || exp_d) begin
        checks++; if (mem_raddr !== (exp_i ? IC_BASE : DC_BASE)) begin failures++; $display("[TB] FAIL fair_addr_k%0d got=%0h exp=%0h", k, mem_raddr, exp_i ? IC_BASE : DC_BASE); end
      end
      if (ic_rdata_ready === 1'b1) ic_pulses++;
      if (dc_rdata_ready === 1'b1) dc_pulses++;
    end
    checks++; if (ic_pulses != 8 || dc_pulses != 8) begin failures++; $display("[TB] FAIL fair_pulse_count got ic=%0d dc=%0d exp 8 8", ic_pulses, dc_pulses); end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_single_icache();
    test_tie();
    test_lock();
    test_early_release();
    test_fairness();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
